stopwatch_ctrl: RTL
===================

Name: stopwatch_ctrl

Overview:
Control stage directly upstream of the stopwatch BCD counter. Synchronises and debounces the front-panel buttons, runs the IDLE/RUNNING/PAUSED state machine, and divides the system clock into the one-cycle count-enable tick. It also generates the counter clear pulse and, optionally, a lap display-hold flag for the display stage.

Parameters:
TICK_DIV, 50_000_000, clk cycles per count tick; must be >= 2.
DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised cycles required to accept a button level change; must be >= 1.

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high; clock clk
btn_start_stop  input  1  raw asynchronous start/stop button, active-high
btn_clear  input  1  raw asynchronous clear button, active-high
btn_lap  input  1  raw asynchronous lap button, active-high; ignored unless LAP_HOLD_EN
cnt_enable  output  1  one-cycle increment pulse to the BCD counter
cnt_clear  output  1  one-cycle registered clear pulse to the BCD counter's reset input
state  output  2  00 IDLE, 01 RUNNING, 10 PAUSED; 11 is never driven
running  output  1  high when state == RUNNING
display_hold  output  1  lap freeze request to the display stage

Behaviour:
- Reset (async): state = IDLE; prescaler = 0; debouncers = 0 with accepted level 0; cnt_enable, cnt_clear, running and display_hold = 0.
- Button path, per button:
  - 2-FF synchroniser.
  - Debouncer: counter of width clog2(DEBOUNCE_CYCLES+1). It counts while the synchronised level differs from the accepted level and resets to 0 when the two match. On reaching DEBOUNCE_CYCLES, the accepted level flips and the counter resets.
  - Press pulse: one cycle, on the rising edge of the accepted level only. Release generates nothing.
- FSM (press pulses registered; new state visible the cycle after the press pulse):
  - IDLE: start_stop -> RUNNING. clear -> stay IDLE and pulse cnt_clear.
  - RUNNING: start_stop -> PAUSED. clear is ignored.
  - PAUSED: start_stop -> RUNNING. clear -> IDLE and pulse cnt_clear.
  - Simultaneous start_stop and clear: in IDLE and PAUSED, clear wins. In RUNNING, start_stop wins (clear is ignored anyway).
- Prescaler (width clog2(TICK_DIV)):
  - Counts 0..TICK_DIV-1 and wraps only while state == RUNNING.
  - Holds its value in PAUSED, so a partial tick period is preserved across pause/resume.
  - Forced to 0 whenever cnt_clear is issued.
- cnt_enable:
  - Registered. High for exactly one cycle, the cycle after the prescaler equals TICK_DIV-1 while state == RUNNING.
  - If start_stop is accepted in that same cycle, the tick is still emitted; the state goes PAUSED simultaneously.
  - Never high in IDLE or PAUSED except for that one carried tick.
  - Back-to-back ticks are exactly TICK_DIV cycles apart.
- cnt_clear: registered; high for one cycle, the cycle after the accepted clear. It never overlaps cnt_enable.
- Reset mid-press or mid-count: everything returns to its reset value immediately. A button still held after reset deasserts must complete a full debounce before the accepted level follows it. Because the reset value of the accepted level is 0, the completed debounce then produces a press pulse.
- running is the registered decode of state; no extra latency versus state.

Optional Feature:
LAP_HOLD_EN
- Defined:
  - A lap press in RUNNING toggles display_hold.
  - A lap press in PAUSED clears display_hold.
  - Entering IDLE clears display_hold.
  - display_hold has no effect on the prescaler or cnt_enable.
  - Lap and start_stop pressed in the same cycle: both take effect.
- Undefined: btn_lap is left unconnected internally (no debouncer instantiated) and display_hold is tied to 0.

Decomposition:
- Package stopwatch_pkg:
  - state encoding constants ST_IDLE=2'b00, ST_RUNNING=2'b01, ST_PAUSED=2'b10;
  - default TICK_DIV and DEBOUNCE_CYCLES values, shared with the counter and display stages.
- Sub-module btn_debounce (synchroniser + debouncer + rising-edge pulse; parameter DEBOUNCE_CYCLES): instantiated per button, 2 instances, or 3 with LAP_HOLD_EN.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3):
- Glitch rejection: hold btn_start_stop high 2 cycles then low -> no press, state stays 00. Hold high 10 cycles -> exactly one press, state 01, one cycle of latency after the press pulse.
- Tick timing: RUNNING for 20 cycles -> cnt_enable pulses exactly 5 times, each one cycle wide, 4 cycles apart. Bench BCD counter sec_ones = 5.
- Pause/resume: pause when prescaler = 2, wait 10 cycles -> no cnt_enable. Resume -> first tick arrives 2 cycles after the prescaler resumes counting (phase preserved).
- Clear: clear while RUNNING -> ignored, no cnt_clear. Pause, then clear -> one-cycle cnt_clear, state 00, prescaler 0, counter digits 0.
- Simultaneous: start_stop and clear accepted in the same cycle in PAUSED -> state 00 and cnt_clear. The same pair in IDLE -> state 00, cnt_clear, no start.
- LAP_HOLD_EN: lap in RUNNING -> display_hold=1 while cnt_enable continues. Second lap -> 0. Lap, pause, clear -> display_hold=0. With the macro undefined -> display_hold stays 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: state encoding and default timing constants
// used by the control, counter and display stages.
package stopwatch_pkg;

    localparam int unsigned TICK_DIV_DEFAULT        = 50_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'b00;
    localparam logic [STATE_W-1:0] ST_RUNNING = 2'b01;
    localparam logic [STATE_W-1:0] ST_PAUSED  = 2'b10;

endpackage

// File: rtl/btn_debounce.sv
// One front-panel button: 2-FF synchroniser, stable-level debouncer and a
// one-cycle press pulse on the accepted rising edge.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             flip_c;

    assign cnt_inc = cnt + CNT_W'(1);
    assign flip_c  = (sync2 != level) && (cnt_inc == CNT_W'(DEBOUNCE_CYCLES));

    // Metastability guard for the raw asynchronous button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip_c) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt_inc;
            end
            press <= flip_c & ~level;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, IDLE/RUNNING/PAUSED FSM and the
// count-tick prescaler. Define LAP_HOLD_EN to enable the lap display hold.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV        = TICK_DIV_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_start_stop,
    input  logic               btn_clear,
    input  logic               btn_lap,
    output logic               cnt_enable,
    output logic               cnt_clear,
    output logic [STATE_W-1:0] state,
    output logic               running,
    output logic               display_hold
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic               p_ss;
    logic               p_clr;
    logic [STATE_W-1:0] state_nx;
    logic [PRE_W-1:0]   presc;
    logic [PRE_W-1:0]   presc_nx;
    logic               clear_c;
    logic               tick_c;
    logic               hold_nx;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_start_stop),
        .press (p_ss)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clear),
        .press (p_clr)
    );

`ifdef LAP_HOLD_EN
    logic p_lap;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lap),
        .press (p_lap)
    );
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
`endif

    // State register plus registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            running      <= 1'b0;
            cnt_enable   <= 1'b0;
            cnt_clear    <= 1'b0;
            presc        <= '0;
            display_hold <= 1'b0;
        end else begin
            state        <= state_nx;
            running      <= (state_nx == ST_RUNNING);
            cnt_enable   <= tick_c;
            cnt_clear    <= clear_c;
            presc        <= presc_nx;
            display_hold <= hold_nx;
        end
    end

    // Next state: clear outranks start_stop wherever clear is honoured.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (!p_clr && p_ss) state_nx = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (p_ss) state_nx = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (p_clr)     state_nx = ST_IDLE;
                else if (p_ss) state_nx = ST_RUNNING;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output decode: tick from the current state, so a pause still carries it.
    always_comb begin
        clear_c  = 1'b0;
        tick_c   = 1'b0;
        presc_nx = presc;
        hold_nx  = display_hold;

        if (state == ST_IDLE || state == ST_PAUSED) begin
            clear_c = p_clr;
        end

        if (state == ST_RUNNING) begin
            tick_c   = (presc == PRE_LAST);
            presc_nx = tick_c ? '0 : presc + PRE_W'(1);
        end

        if (clear_c) begin
            presc_nx = '0;
        end

`ifdef LAP_HOLD_EN
        if (state_nx == ST_IDLE) begin
            hold_nx = 1'b0;
        end else if (p_lap && state == ST_RUNNING) begin
            hold_nx = ~display_hold;
        end else if (p_lap && state == ST_PAUSED) begin
            hold_nx = 1'b0;
        end
`else
        hold_nx = 1'b0;
`endif
    end

endmodule
